// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one pulse-protocol memory bus between two requesters.
// Port 0 is instruction fetch and port 1 is the mem stage. Each port has one
// pending slot. One bus transaction is outstanding at a time. Responses are
// routed back to the owning port, and a timeout guards the bus.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   mX_request_enable/mode/addr/wdata/wstrb   port X request pulse and fields
//   mX_response_enable/data    port X completion pulse and read data
//   request_enable/mode/addr/wdata/wstrb      bus request pulse and fields
//   response_enable/data       bus completion pulse and read data
//   grant_id                   owner of the current or last transaction
//   bus_timeout                one-cycle pulse when a timeout fires
//   protocol_error             sticky flag for a dropped request
module bus_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_request_enable,
  input  logic        m0_mode,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_response_enable,
  output logic [31:0] m0_data,
  input  logic        m1_request_enable,
  input  logic        m1_mode,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_response_enable,
  output logic [31:0] m1_data,
  output logic        request_enable,
  output logic        mode,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        response_enable,
  input  logic [31:0] data,
  output logic        grant_id,
  output logic        bus_timeout,
  output logic        protocol_error
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds completed silent BUSY cycles; the edge that would make
  // it reach TIMEOUT_CYCLES is the one that fires.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic          valid;
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } slot_t;

  state_t        state_q;
  slot_t         slot0_q, slot1_q;
  slot_t         live0, live1;
  logic          last_grant_q;
  logic [CW-1:0] count_q;

  logic          eff0, eff1, win, do_grant;
  logic          win_mode;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [SW-1:0] win_wstrb;
  logic          limit_hit, rsp_done, to_done, finishing;
  logic          drop0, drop1, load0, load1;

  assign live0 = {m0_request_enable, m0_mode, m0_addr, m0_wdata, m0_wstrb};
  assign live1 = {m1_request_enable, m1_mode, m1_addr, m1_wdata, m1_wstrb};

  // Arbitration, completion detection and slot capture decisions.
  always_comb begin
    eff0      = slot0_q.valid | m0_request_enable;
    eff1      = slot1_q.valid | m1_request_enable;
    win       = eff1;
    if (eff0 && eff1) begin
      win = (PRIORITY_MODE != 0) ? 1'b1 : ~last_grant_q;
    end
    do_grant  = (state_q == IDLE) && (eff0 || eff1);

    // A pending slot takes precedence over the live inputs of its port.
    win_mode  = m0_mode;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    win_wstrb = m0_wstrb;
    if (win) begin
      if (slot1_q.valid) begin
        win_mode = slot1_q.mode; win_addr = slot1_q.addr;
        win_wdata = slot1_q.wdata; win_wstrb = slot1_q.wstrb;
      end else begin
        win_mode = m1_mode; win_addr = m1_addr;
        win_wdata = m1_wdata; win_wstrb = m1_wstrb;
      end
    end else if (slot0_q.valid) begin
      win_mode = slot0_q.mode; win_addr = slot0_q.addr;
      win_wdata = slot0_q.wdata; win_wstrb = slot0_q.wstrb;
    end

    limit_hit = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);
    rsp_done  = (state_q == BUSY) && response_enable;
    to_done   = (state_q == BUSY) && !response_enable && limit_hit;
    finishing = rsp_done | to_done;

    // The owner of a transaction that is not completing this edge is busy.
    drop0 = m0_request_enable &&
            (slot0_q.valid || ((state_q == BUSY) && !grant_id && !finishing));
    drop1 = m1_request_enable &&
            (slot1_q.valid || ((state_q == BUSY) && grant_id && !finishing));
    // A live request that wins immediately never occupies its slot.
    load0 = m0_request_enable && !drop0 && !(do_grant && !win);
    load1 = m1_request_enable && !drop1 && !(do_grant && win);
  end

  // State, slots and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      slot0_q            <= '0;
      slot1_q            <= '0;
      last_grant_q       <= 1'b1;
      count_q            <= '0;
      request_enable     <= 1'b0;
      mode               <= 1'b0;
      addr               <= '0;
      wdata              <= '0;
      wstrb              <= '0;
      grant_id           <= 1'b0;
      m0_response_enable <= 1'b0;
      m1_response_enable <= 1'b0;
      m0_data            <= '0;
      m1_data            <= '0;
      bus_timeout        <= 1'b0;
      protocol_error     <= 1'b0;
    end else begin
      request_enable     <= 1'b0;
      m0_response_enable <= 1'b0;
      m1_response_enable <= 1'b0;
      bus_timeout        <= 1'b0;

      if (drop0 || drop1) protocol_error <= 1'b1;

      if (load0)                 slot0_q       <= live0;
      else if (do_grant && !win) slot0_q.valid <= 1'b0;
      if (load1)                 slot1_q       <= live1;
      else if (do_grant && win)  slot1_q.valid <= 1'b0;

      case (state_q)
        IDLE: begin
          if (do_grant) begin
            state_q        <= BUSY;
            request_enable <= 1'b1;
            mode           <= win_mode;
            addr           <= win_addr;
            wdata          <= win_wdata;
            wstrb          <= win_wstrb;
            grant_id       <= win;
            last_grant_q   <= win;
          end
        end
        BUSY: begin
          if (finishing) begin
            state_q     <= IDLE;
            count_q     <= '0;
            bus_timeout <= to_done;
            if (grant_id) begin
              m1_response_enable <= 1'b1;
              m1_data            <= rsp_done ? data : '0;
            end else begin
              m0_response_enable <= 1'b1;
              m0_data            <= rsp_done ? data : '0;
            end
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven and directed checks plus a randomized run
// against a transaction-level model of the arbiter.
module tb_bus_arbiter;

  localparam int unsigned TO_A = 8;
  localparam int unsigned TO_P = 4;
  localparam logic [31:0] A0  = 32'h0000_1000;
  localparam logic [31:0] A1  = 32'h0000_2000;
  localparam logic [31:0] WD1 = 32'h55AA_55AA;
  localparam logic [3:0]  WS0 = 4'hF;
  localparam logic [3:0]  WS1 = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_request_enable, m0_mode, m1_request_enable, m1_mode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, data;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        response_enable;

  logic        m0_response_enable, m1_response_enable, request_enable, mode;
  logic        grant_id, bus_timeout, protocol_error;
  logic [31:0] m0_data, m1_data, addr, wdata;
  logic [3:0]  wstrb;

  logic        m0_response_enable_p, m1_response_enable_p, request_enable_p, mode_p;
  logic        grant_id_p, bus_timeout_p, protocol_error_p;
  logic [31:0] m0_data_p, m1_data_p, addr_p, wdata_p;
  logic [3:0]  wstrb_p;

  always #5 clk = ~clk;

  bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO_A)) dut (
    .clk(clk), .rst(rst),
    .m0_request_enable(m0_request_enable), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_response_enable(m0_response_enable), .m0_data(m0_data),
    .m1_request_enable(m1_request_enable), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_response_enable(m1_response_enable), .m1_data(m1_data),
    .request_enable(request_enable), .mode(mode), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .response_enable(response_enable), .data(data),
    .grant_id(grant_id), .bus_timeout(bus_timeout), .protocol_error(protocol_error)
  );

  bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO_P)) dut_p (
    .clk(clk), .rst(rst),
    .m0_request_enable(m0_request_enable), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_response_enable(m0_response_enable_p), .m0_data(m0_data_p),
    .m1_request_enable(m1_request_enable), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_response_enable(m1_response_enable_p), .m1_data(m1_data_p),
    .request_enable(request_enable_p), .mode(mode_p), .addr(addr_p), .wdata(wdata_p),
    .wstrb(wstrb_p), .response_enable(response_enable), .data(data),
    .grant_id(grant_id_p), .bus_timeout(bus_timeout_p), .protocol_error(protocol_error_p)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_a();
    return {request_enable, grant_id, m0_response_enable, m1_response_enable,
            bus_timeout, protocol_error};
  endfunction

  function automatic logic [68:0] bus_a();
    return {mode, wstrb, addr, wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_request_enable = 1'b0;
    m1_request_enable = 1'b0;
    response_enable   = 1'b0;
    data              = '0;
  endtask

  task automatic set_fixed();
    m0_mode = 1'b0; m0_addr = A0; m0_wdata = '0;  m0_wstrb = WS0;
    m1_mode = 1'b1; m1_addr = A1; m1_wdata = WD1; m1_wstrb = WS1;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic        mode;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        pend0[$];
  txn_t        pend1[$];
  bit          m_busy, m_owner, m_last, out0, out1;
  int          m_deadline, m_cyc;
  logic        e_req, e_gid, e_r0, e_r1, e_to;
  txn_t        e_bus;
  logic [31:0] e_d0, e_d1;

  task automatic model_reset();
    pend0.delete(); pend1.delete();
    m_busy = 0; m_owner = 0; m_last = 1; out0 = 0; out1 = 0;
    m_deadline = 0; m_cyc = 0;
    e_req = 0; e_gid = 0; e_r0 = 0; e_r1 = 0; e_to = 0;
    e_bus = '0; e_d0 = '0; e_d1 = '0;
  endtask

  task automatic finish_txn(input logic [31:0] d);
    if (m_owner) begin e_r1 = 1; e_d1 = d; out1 = 0; end
    else         begin e_r0 = 1; e_d0 = d; out0 = 0; end
    m_busy = 0;
  endtask

  // One clock edge: complete the outstanding transfer or issue the next one.
  task automatic model_step();
    txn_t t0, t1;
    bit   pick;
    t0 = {m0_mode, m0_wstrb, m0_addr, m0_wdata};
    t1 = {m1_mode, m1_wstrb, m1_addr, m1_wdata};
    e_req = 0; e_r0 = 0; e_r1 = 0; e_to = 0;
    if (m_busy) begin
      if (response_enable) finish_txn(data);
      else if (m_cyc == m_deadline) begin finish_txn('0); e_to = 1; end
      if (m0_request_enable) pend0.push_back(t0);
      if (m1_request_enable) pend1.push_back(t1);
    end else begin
      if (m0_request_enable) pend0.push_back(t0);
      if (m1_request_enable) pend1.push_back(t1);
      if (pend0.size() != 0 || pend1.size() != 0) begin
        if (pend0.size() != 0 && pend1.size() != 0) pick = !m_last;
        else pick = (pend1.size() != 0);
        e_bus = pick ? pend1.pop_front() : pend0.pop_front();
        e_req = 1; e_gid = pick; m_last = pick;
        m_busy = 1; m_owner = pick; m_deadline = m_cyc + int'(TO_A);
      end
    end
    m_cyc++;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  in;    // {m0_request_enable, m1_request_enable, response_enable}
    logic [31:0] rdata;
    logic [3:0]  ex;    // {request_enable, grant_id, m0_response, m1_response}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic [2:0] in, input logic [31:0] rd, input logic [3:0] ex);
    vec_t v;
    v.in = in; v.rdata = rd; v.ex = ex;
    return v;
  endfunction

  initial begin
    logic [31:0] ed0, ed1;
    logic        gid;

    set_fixed();
    do_reset();
    chk("reset ctrl", ctrl_a(), '0);
    chk("reset bus", bus_a(), '0);
    chk("reset data", {m0_data, m1_data}, '0);

    tbl.push_back(row(3'b110, 32'h0,         4'b1000)); // tie after reset: port 0
    tbl.push_back(row(3'b000, 32'h0,         4'b0000));
    tbl.push_back(row(3'b001, 32'h1111_1111, 4'b0010));
    tbl.push_back(row(3'b000, 32'h0,         4'b1100)); // port 1 two cycles later
    tbl.push_back(row(3'b000, 32'h0,         4'b0100));
    tbl.push_back(row(3'b001, 32'h2222_2222, 4'b0101));
    tbl.push_back(row(3'b100, 32'h0,         4'b1000)); // single read
    tbl.push_back(row(3'b000, 32'h0,         4'b0000));
    tbl.push_back(row(3'b000, 32'h0,         4'b0000));
    tbl.push_back(row(3'b000, 32'h0,         4'b0000));
    tbl.push_back(row(3'b001, 32'hCAFE_BABE, 4'b0010));
    tbl.push_back(row(3'b110, 32'h0,         4'b1100)); // second tie: port 1
    tbl.push_back(row(3'b000, 32'h0,         4'b0100));
    tbl.push_back(row(3'b001, 32'h3333_3333, 4'b0101));
    tbl.push_back(row(3'b000, 32'h0,         4'b1000));
    tbl.push_back(row(3'b001, 32'h4444_4444, 4'b0010)); // reply in first BUSY cycle
    tbl.push_back(row(3'b001, 32'h5555_5555, 4'b0000)); // late reply ignored
    tbl.push_back(row(3'b100, 32'h0,         4'b1000));
    tbl.push_back(row(3'b010, 32'h0,         4'b0000)); // pending while busy
    tbl.push_back(row(3'b001, 32'h6666_6666, 4'b0010));
    tbl.push_back(row(3'b000, 32'h0,         4'b1100));
    tbl.push_back(row(3'b001, 32'h7777_7777, 4'b0101));
    tbl.push_back(row(3'b100, 32'h0,         4'b1000));
    tbl.push_back(row(3'b011, 32'h8888_8888, 4'b0010)); // reply plus new request
    tbl.push_back(row(3'b000, 32'h0,         4'b1100));
    tbl.push_back(row(3'b001, 32'h9999_9999, 4'b0101));

    ed0 = '0; ed1 = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      {m0_request_enable, m1_request_enable, response_enable} = tbl[i].in;
      data = tbl[i].rdata;
      tick();
      if (tbl[i].ex[1]) ed0 = tbl[i].rdata;
      if (tbl[i].ex[0]) ed1 = tbl[i].rdata;
      gid = tbl[i].ex[2];
      chk($sformatf("row%0d ctrl", i), ctrl_a(),
          {tbl[i].ex[3], gid, tbl[i].ex[1], tbl[i].ex[0], 2'b00});
      chk($sformatf("row%0d bus", i), bus_a(),
          gid ? {1'b1, WS1, A1, WD1} : {1'b0, WS0, A0, 32'h0});
      chk($sformatf("row%0d data", i), {m0_data, m1_data}, {ed0, ed1});
      if (i == 0)
        chk("fixed prio tie", {request_enable_p, grant_id_p, addr_p, wstrb_p},
            {1'b1, 1'b1, A1, WS1});
    end
    idle_in();

    // ---- timeout on the 4-cycle instance ----
    do_reset();
    m0_request_enable = 1'b1; tick(); m0_request_enable = 1'b0;
    chk("to grant", {request_enable_p, grant_id_p, addr_p}, {1'b1, 1'b0, A0});
    response_enable = 1'b1; data = 32'hABCD_0123; tick(); idle_in();
    chk("to first read", {m0_response_enable_p, m0_data_p}, {1'b1, 32'hABCD_0123});
    m0_request_enable = 1'b1; tick(); m0_request_enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("to quiet %0d", k), {bus_timeout_p, m0_response_enable_p}, 2'b00);
    end
    tick();
    chk("to fire", {bus_timeout_p, m0_response_enable_p, m1_response_enable_p, m0_data_p},
        {1'b1, 1'b1, 1'b0, 32'h0});
    chk("to limit8 quiet", {bus_timeout, m0_response_enable}, 2'b00);
    tick();
    chk("to pulse end", {bus_timeout_p, m0_response_enable_p}, 2'b00);
    response_enable = 1'b1; data = 32'hDEAD_BEEF; tick(); idle_in();
    chk("late rsp ignored", {m0_response_enable_p, request_enable_p, m0_data_p},
        {1'b0, 1'b0, 32'h0});

    // ---- protocol error, then reset mid-BUSY ----
    do_reset();
    m1_request_enable = 1'b1; tick(); m1_request_enable = 1'b0;
    m0_request_enable = 1'b1; tick();
    chk("perr clear", {protocol_error, request_enable, grant_id}, 3'b001);
    tick(); m0_request_enable = 1'b0;
    chk("perr double pulse", protocol_error, 1'b1);
    rst = 1'b1; #1;
    chk("async rst ctrl", ctrl_a(), '0);
    chk("async rst bus", bus_a(), '0);
    @(posedge clk); #1; rst = 1'b0;
    response_enable = 1'b1; data = 32'h1234_5678; tick(); idle_in();
    chk("abandoned no rsp", {ctrl_a(), m1_data}, '0);
    tick();
    chk("slot cleared", ctrl_a(), '0);
    m0_request_enable = 1'b1; tick(); m0_request_enable = 1'b0;
    chk("post rst grant", {request_enable, grant_id, addr}, {1'b1, 1'b0, A0});
    response_enable = 1'b1; data = 32'hFEED_F00D; tick(); idle_in();
    chk("post rst rsp", {m0_response_enable, m0_data}, {1'b1, 32'hFEED_F00D});

    // ---- randomized run against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      m0_request_enable = !out0 && ($urandom_range(99) < 35);
      m1_request_enable = !out1 && ($urandom_range(99) < 35);
      if (m0_request_enable) out0 = 1;
      if (m1_request_enable) out1 = 1;
      m0_mode = 1'($urandom); m0_addr = $urandom & 32'hFFFF_FFFC;
      m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      m1_mode = 1'($urandom); m1_addr = $urandom & 32'hFFFF_FFFC;
      m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      response_enable = ($urandom_range(99) < 25);
      data = $urandom;
      tick();
      model_step();
      chk($sformatf("rand%0d ctrl", c), ctrl_a(), {e_req, e_gid, e_r0, e_r1, e_to, 1'b0});
      chk($sformatf("rand%0d bus", c), bus_a(), e_bus);
      chk($sformatf("rand%0d data", c), {m0_data, m1_data}, {e_d0, e_d1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
